// File: rtl/prog_loader_pkg.sv
// Shared types and TRSQ8 ISA constants for the boot-time instruction loader.
// The opcode codes and instruction width here are the same ones the core's
// decoder keys on, so the loader rejects exactly what the decoder cannot run.
package prog_loader_pkg;

    localparam int INSTR_W = 15;

    // Instruction classes, word[14:13]
    localparam logic [1:0] CLASS_SYS  = 2'b00;
    localparam logic [1:0] CLASS_ALU  = 2'b01;
    localparam logic [1:0] CLASS_BIT  = 2'b10;
    localparam logic [1:0] CLASS_JUMP = 2'b11;

    // Class 00 opcodes, word[14:8]
    localparam logic [6:0] OP_NOP  = 7'b0000000;
    localparam logic [6:0] OP_HALT = 7'b0000001;
    localparam logic [6:0] OP_RET  = 7'b0000010;
    localparam logic [6:0] OP_SKZ  = 7'b0000101;
    localparam logic [6:0] OP_SKC  = 7'b0000110;

    // Class 01 opcodes, word[14:8]
    localparam logic [6:0] OP_ADD  = 7'b0100000;
    localparam logic [6:0] OP_SUB  = 7'b0100001;
    localparam logic [6:0] OP_AND  = 7'b0100111;
    localparam logic [6:0] OP_OR   = 7'b0101000;
    localparam logic [6:0] OP_NOT  = 7'b0101001;
    localparam logic [6:0] OP_XOR  = 7'b0101011;
    localparam logic [6:0] OP_ST   = 7'b0101100;
    localparam logic [6:0] OP_LD   = 7'b0101101;
    localparam logic [6:0] OP_LDL  = 7'b0101110;

    // err_code values
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_WORD = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CNT  = 3'd1,
        S_LO   = 3'd2,
        S_HI   = 3'd3,
        S_CSUM = 3'd4
    } state_t;

endpackage

// File: rtl/prog_opcode_check.sv
// Combinational legality check of one TRSQ8 instruction word against the
// opcode map. Bit and jump classes accept any sub-opcode.
module prog_opcode_check
    import prog_loader_pkg::*;
(
    input  logic [INSTR_W-1:0] word,
    output logic               legal
);

    logic [6:0] opcode;
    logic       unused_low;

    assign opcode     = word[14:8];
    // Operand byte plays no part in legality.
    assign unused_low = ^word[7:0];

    // Decode the opcode field by class.
    always_comb begin
        legal = 1'b0;
        case (opcode[6:5])
            CLASS_SYS: begin
                legal = (opcode == OP_NOP) || (opcode == OP_HALT) ||
                        (opcode == OP_RET) || (opcode == OP_SKZ)  ||
                        (opcode == OP_SKC);
            end
            CLASS_ALU: begin
                legal = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                        (opcode == OP_AND) || (opcode == OP_OR)  ||
                        (opcode == OP_NOT) || (opcode == OP_XOR) ||
                        (opcode == OP_ST)  || (opcode == OP_LD)  ||
                        (opcode == OP_LDL);
            end
            CLASS_BIT:  legal = 1'b1;
            CLASS_JUMP: legal = 1'b1;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Boot-time instruction-memory writer. Parses a framed byte stream
// (SYNC, N, N x {lo, hi}, checksum), writes legal words sequentially and
// releases the core only after a frame loads without error.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for SYNC; other bytes are dropped
// CNT    | next byte is the word count (0 means 256)
// LO     | next byte is the low byte of a word
// HI     | next byte is the high byte; word is checked and written
// CSUM   | next byte is the frame checksum
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] SYNC   = 8'hA5
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid_ip,
    input  logic [7:0]          rx_data_ip,
    output logic                imem_we_op,
    output logic [ADDR_W-1:0]   imem_addr_op,
    output logic [INSTR_W-1:0]  imem_data_op,
    output logic                cpu_hold_op,
    output logic                done_op,
    output logic                err_op,
    output logic [1:0]          err_code_op
);

    state_t             state;
    state_t             state_d;
    logic [7:0]         lo_byte;
    logic [8:0]         words_left;
    logic [7:0]         sum;
    logic [7:0]         sum_next;
    logic               addr_adv;
    logic [INSTR_W-1:0] word;
    logic               word_legal;
    logic               word_bad;

    logic start;
    logic lat_cnt;
    logic lat_lo;
    logic word_done;
    logic csum_chk;

    assign word     = {rx_data_ip[6:0], lo_byte};
    assign word_bad = rx_data_ip[7] | ~word_legal;
    assign sum_next = sum + rx_data_ip;

    prog_opcode_check u_opcode_check (
        .word  (word),
        .legal (word_legal)
    );

    // Next state and per-byte actions; only a strobed byte moves the FSM.
    always_comb begin
        state_d   = state;
        start     = 1'b0;
        lat_cnt   = 1'b0;
        lat_lo    = 1'b0;
        word_done = 1'b0;
        csum_chk  = 1'b0;
        if (rx_valid_ip) begin
            case (state)
                S_IDLE: begin
                    if (rx_data_ip == SYNC) begin
                        start   = 1'b1;
                        state_d = S_CNT;
                    end
                end
                S_CNT: begin
                    lat_cnt = 1'b1;
                    state_d = S_LO;
                end
                S_LO: begin
                    lat_lo  = 1'b1;
                    state_d = S_HI;
                end
                S_HI: begin
                    word_done = 1'b1;
                    state_d   = (words_left == 9'd1) ? S_CSUM : S_LO;
                end
                S_CSUM: begin
                    csum_chk = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Datapath: byte/word capture, running sum, address, write and status flags.
    // The address advances the cycle after a word so it is stable during the
    // write strobe; suppressed words advance it too, preserving word positions.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_byte      <= '0;
            words_left   <= '0;
            sum          <= '0;
            addr_adv     <= 1'b0;
            imem_we_op   <= 1'b0;
            imem_addr_op <= '0;
            imem_data_op <= '0;
            cpu_hold_op  <= 1'b1;
            done_op      <= 1'b0;
            err_op       <= 1'b0;
            err_code_op  <= ERR_NONE;
        end else begin
            imem_we_op <= 1'b0;
            done_op    <= 1'b0;
            addr_adv   <= 1'b0;
            if (addr_adv) begin
                imem_addr_op <= imem_addr_op + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            if (start) begin
                imem_addr_op <= '0;
                sum          <= '0;
                cpu_hold_op  <= 1'b1;
                err_op       <= 1'b0;
                err_code_op  <= ERR_NONE;
            end
            if (lat_cnt) begin
                words_left <= (rx_data_ip == 8'd0) ? 9'd256 : {1'b0, rx_data_ip};
            end
            if (lat_lo) begin
                lo_byte <= rx_data_ip;
                sum     <= sum_next;
            end
            if (word_done) begin
                sum        <= sum_next;
                words_left <= words_left - 9'd1;
                addr_adv   <= 1'b1;
                if (word_bad) begin
                    if (!err_op) begin
                        err_op      <= 1'b1;
                        err_code_op <= ERR_WORD;
                    end
                end else begin
                    imem_we_op   <= 1'b1;
                    imem_data_op <= word;
                end
            end
            if (csum_chk) begin
                if (sum_next != 8'd0) begin
                    if (!err_op) begin
                        err_op      <= 1'b1;
                        err_code_op <= ERR_CSUM;
                    end
                end else if (!err_op) begin
                    done_op     <= 1'b1;
                    cpu_hold_op <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a table of single-word frames covering the
// opcode map and checksum outcomes, plus hand-written multi-cycle sequences.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid_ip;
    logic [7:0]        rx_data_ip;
    logic              imem_we_op;
    logic [ADDR_W-1:0] imem_addr_op;
    logic [14:0]       imem_data_op;
    logic              cpu_hold_op;
    logic              done_op;
    logic              err_op;
    logic [1:0]        err_code_op;

    int total = 0;
    int bad   = 0;

    int wr_cnt   = 0;
    int done_cnt = 0;
    logic [ADDR_W-1:0] wr_addr [0:1023];
    logic [14:0]       wr_data [0:1023];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid_ip  (rx_valid_ip),
        .rx_data_ip   (rx_data_ip),
        .imem_we_op   (imem_we_op),
        .imem_addr_op (imem_addr_op),
        .imem_data_op (imem_data_op),
        .cpu_hold_op  (cpu_hold_op),
        .done_op      (done_op),
        .err_op       (err_op),
        .err_code_op  (err_code_op)
    );

    // Log every write strobe and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we_op) begin
            if (wr_cnt < 1024) begin
                wr_addr[wr_cnt] = imem_addr_op;
                wr_data[wr_cnt] = imem_data_op;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (done_op) done_cnt = done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid_ip = 1'b1;
        rx_data_ip  = b;
        @(posedge clk);
        #1;
        rx_valid_ip = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"},   32'(imem_we_op),   32'd0);
        check({tag, "_addr"}, 32'(imem_addr_op), 32'd0);
        check({tag, "_data"}, 32'(imem_data_op), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold_op),  32'd1);
        check({tag, "_done"}, 32'(done_op),      32'd0);
        check({tag, "_err"},  32'(err_op),       32'd0);
        check({tag, "_code"}, 32'(err_code_op),  32'd0);
    endtask

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        bit         good_sum;
        bit         exp_wr;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int w0;
        int d0;
        logic [7:0] cs;
        logic [7:0] s;
        logic [7:0] ib;
        int addr_bad;
        int data_bad;
        bit exp_done;

        vecs[0]  = '{8'h00, 8'h00, 1'b1, 1'b1, 2'b00};  // NOP
        vecs[1]  = '{8'h34, 8'h01, 1'b1, 1'b1, 2'b00};  // HALT
        vecs[2]  = '{8'h00, 8'h03, 1'b1, 1'b0, 2'b01};  // 0000011 illegal
        vecs[3]  = '{8'h12, 8'h06, 1'b1, 1'b1, 2'b00};  // SKC
        vecs[4]  = '{8'h00, 8'h07, 1'b1, 1'b0, 2'b01};  // 0000111 illegal
        vecs[5]  = '{8'hFF, 8'h2E, 1'b1, 1'b1, 2'b00};  // LDL
        vecs[6]  = '{8'h00, 8'h2F, 1'b1, 1'b0, 2'b01};  // 0101111 illegal
        vecs[7]  = '{8'h00, 8'h2A, 1'b1, 1'b0, 2'b01};  // 0101010 illegal
        vecs[8]  = '{8'h55, 8'h5F, 1'b1, 1'b1, 2'b00};  // bit class
        vecs[9]  = '{8'hAA, 8'h7F, 1'b1, 1'b1, 2'b00};  // jump class
        vecs[10] = '{8'h00, 8'h80, 1'b1, 1'b0, 2'b01};  // bit 15 set
        vecs[11] = '{8'h00, 8'h20, 1'b0, 1'b1, 2'b10};  // ADD, bad checksum
        vecs[12] = '{8'h00, 8'h23, 1'b0, 1'b0, 2'b01};  // illegal, then bad checksum
        vecs[13] = '{8'h00, 8'h29, 1'b1, 1'b1, 2'b00};  // NOT
        vecs[14] = '{8'h00, 8'h80, 1'b0, 1'b0, 2'b01};  // bit 15, then bad checksum
        vecs[15] = '{8'h00, 8'h04, 1'b1, 1'b0, 2'b01};  // 0000100 illegal
        vecs[16] = '{8'h07, 8'h02, 1'b1, 1'b1, 2'b00};  // RET
        vecs[17] = '{8'h00, 8'h22, 1'b1, 1'b0, 2'b01};  // 0100010 illegal

        rst         = 1'b1;
        rx_valid_ip = 1'b0;
        rx_data_ip  = 8'h00;
        idle(3);
        check_reset_values("rst_in");
        rst = 1'b0;
        idle(2);
        check_reset_values("rst_out");

        // Table of single-word frames.
        for (int i = 0; i < 18; i++) begin
            w0 = wr_cnt;
            d0 = done_cnt;
            cs = 8'h00 - vecs[i].lo - vecs[i].hi;
            if (!vecs[i].good_sum) cs = cs + 8'h01;
            exp_done = (vecs[i].exp_code == 2'b00);
            send_byte(8'hA5);
            send_byte(8'h01);
            send_byte(vecs[i].lo);
            send_byte(vecs[i].hi);
            send_byte(cs);
            idle(2);
            check($sformatf("v%0d_wr_count", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr && (wr_cnt > w0)) begin
                check($sformatf("v%0d_wr_data", i), 32'(wr_data[w0]), 32'({vecs[i].hi[6:0], vecs[i].lo}));
                check($sformatf("v%0d_wr_addr", i), 32'(wr_addr[w0]), 32'd0);
            end
            check($sformatf("v%0d_done", i), 32'(done_cnt - d0), 32'(exp_done));
            check($sformatf("v%0d_err", i),  32'(err_op), 32'(!exp_done));
            check($sformatf("v%0d_code", i), 32'(err_code_op), 32'(vecs[i].exp_code));
            check($sformatf("v%0d_hold", i), 32'(cpu_hold_op), 32'(!exp_done));
        end

        // Good two-word frame: write latency, done timing, then SYNC straight after.
        w0 = wr_cnt;
        d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h20);
        check("good_w0_we",   32'(imem_we_op),   32'd1);
        check("good_w0_addr", 32'(imem_addr_op), 32'd0);
        check("good_w0_data", 32'(imem_data_op), 32'h2000);
        send_byte(8'h05);
        check("good_addr_adv", 32'(imem_addr_op), 32'd1);
        send_byte(8'h41);
        check("good_w1_we",   32'(imem_we_op),   32'd1);
        check("good_w1_addr", 32'(imem_addr_op), 32'd1);
        check("good_w1_data", 32'(imem_data_op), 32'h4105);
        send_byte(8'h9A);
        check("good_done",  32'(done_op),     32'd1);
        check("good_hold",  32'(cpu_hold_op), 32'd0);
        check("good_err",   32'(err_op),      32'd0);
        send_byte(8'hA5);
        check("b2b_done_pulse", 32'(done_op),     32'd0);
        check("b2b_hold_rise",  32'(cpu_hold_op), 32'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h05);
        send_byte(8'h41);
        send_byte(8'h9A);
        idle(2);
        check("b2b_wr_count", 32'(wr_cnt - w0),   32'd4);
        check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
        check("b2b_addr2",    32'(wr_addr[w0+2]), 32'd0);
        check("b2b_addr3",    32'(wr_addr[w0+3]), 32'd1);
        check("b2b_data3",    32'(wr_data[w0+3]), 32'h4105);
        check("b2b_hold",     32'(cpu_hold_op),   32'd0);

        // Same frame with a bad checksum.
        w0 = wr_cnt;
        d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h05);
        send_byte(8'h41);
        send_byte(8'h9B);
        idle(2);
        check("csum_wr_count", 32'(wr_cnt - w0),   32'd2);
        check("csum_done",     32'(done_cnt - d0), 32'd0);
        check("csum_err",      32'(err_op),        32'd1);
        check("csum_code",     32'(err_code_op),   32'd2);
        check("csum_hold",     32'(cpu_hold_op),   32'd1);

        // Illegal first word: write suppressed but the next word lands at addr 1.
        w0 = wr_cnt;
        d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h23);
        check("supp_we", 32'(imem_we_op), 32'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        check("supp_next_addr", 32'(imem_addr_op), 32'd1);
        check("supp_next_data", 32'(imem_data_op), 32'h0100);
        send_byte(8'hDC);
        idle(2);
        check("supp_wr_count", 32'(wr_cnt - w0),   32'd1);
        check("supp_done",     32'(done_cnt - d0), 32'd0);
        check("supp_code",     32'(err_code_op),   32'd1);

        // 256-word frame, one byte every cycle; address wraps at the end.
        w0 = wr_cnt;
        d0 = done_cnt;
        s  = 8'h00;
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            send_byte(ib);
            send_byte(8'h60);
            s = s + ib + 8'h60;
        end
        send_byte(8'h00 - s);
        idle(2);
        check("big_wr_count", 32'(wr_cnt - w0),   32'd256);
        addr_bad = 0;
        data_bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (w0 + i < 1024) begin
                if (wr_addr[w0+i] !== 8'(i)) addr_bad++;
                if (wr_data[w0+i] !== {7'h60, 8'(i)}) data_bad++;
            end
        end
        check("big_addr_seq", 32'(addr_bad),      32'd0);
        check("big_data_seq", 32'(data_bad),      32'd0);
        check("big_done",     32'(done_cnt - d0), 32'd1);
        check("big_err",      32'(err_op),        32'd0);
        check("big_addr_wrap", 32'(imem_addr_op), 32'd0);

        // Reset after the third data byte aborts the frame.
        w0 = wr_cnt;
        d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h05);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check_reset_values("abort");
        send_byte(8'h41);
        send_byte(8'h9A);
        idle(2);
        check("abort_wr_count", 32'(wr_cnt - w0),   32'd1);
        check("abort_done",     32'(done_cnt - d0), 32'd0);
        check("abort_hold",     32'(cpu_hold_op),   32'd1);
        w0 = wr_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h05);
        send_byte(8'h41);
        send_byte(8'h9A);
        idle(2);
        check("reload_wr_count", 32'(wr_cnt - w0),   32'd2);
        check("reload_addr0",    32'(wr_addr[w0]),   32'd0);
        check("reload_addr1",    32'(wr_addr[w0+1]), 32'd1);
        check("reload_data0",    32'(wr_data[w0]),   32'h2000);
        check("reload_done",     32'(done_cnt - d0), 32'd1);
        check("reload_hold",     32'(cpu_hold_op),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
